// File: rtl/mem_access_unit_if.sv
// EX-side handshake, data-memory port and writeback bus of the MEM-stage unit.
// "master" is the unit itself (it masters the memory port); "slave" is the surrounding pipeline/memory.
interface mem_access_unit_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_load;
    logic              ex_store;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_regwrite;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              wb_valid;
    logic              wb_regwrite;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_is_load;

    logic [CNT_W-1:0]  ld_count;
    logic [CNT_W-1:0]  st_count;
    logic              fault;

    modport master (
        input  ex_valid, ex_load, ex_store, ex_alu_result, ex_store_data, ex_rd, ex_regwrite,
        input  mem_rdata,
        output ex_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output wb_valid, wb_regwrite, wb_rd, wb_data, wb_is_load,
        output ld_count, st_count, fault
    );

    modport slave (
        output ex_valid, ex_load, ex_store, ex_alu_result, ex_store_data, ex_rd, ex_regwrite,
        output mem_rdata,
        input  ex_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  wb_valid, wb_regwrite, wb_rd, wb_data, wb_is_load,
        input  ld_count, st_count, fault
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage controller: drives the data memory, captures load data, produces MEM/WB results.
// Optional macro MEM_ADDR_CHECK_EN enables out-of-range address faulting.
module mem_access_unit #(
    parameter int DATA_W    = 19,
    parameter int ADDR_W    = 8,
    parameter int REG_W     = 3,
    parameter int MEM_DEPTH = 226,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, LD_ISSUE, LD_CAPTURE} state_t;

    localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(MEM_DEPTH);

    state_t           state;
    logic [REG_W-1:0] ld_rd_p1;
    logic             ld_rw_p1;
    logic             ld_flt_p1;
    logic             addr_fault;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign bus.ex_ready = (state == IDLE);

`ifdef MEM_ADDR_CHECK_EN
    assign addr_fault = (bus.ex_alu_result >= DEPTH_LIM);
`else
    logic unused_depth;
    assign unused_depth = ^DEPTH_LIM;
    assign addr_fault   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_regwrite <= 1'b0;
            bus.wb_rd       <= '0;
            bus.wb_data     <= '0;
            bus.wb_is_load  <= 1'b0;
            bus.ld_count    <= '0;
            bus.st_count    <= '0;
            bus.fault       <= 1'b0;
            ld_rd_p1        <= '0;
            ld_rw_p1        <= 1'b0;
            ld_flt_p1       <= 1'b0;
        end else begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.wb_valid  <= 1'b0;
            bus.fault     <= 1'b0;
            case (state)
                // Accept stage: ALU and store results retire next cycle, loads start issuing.
                IDLE: begin
                    if (bus.ex_valid) begin
                        if (bus.ex_load) begin
                            state     <= LD_ISSUE;
                            ld_rd_p1  <= bus.ex_rd;
                            ld_rw_p1  <= bus.ex_regwrite;
                            ld_flt_p1 <= addr_fault;
                            if (!addr_fault) begin
                                bus.mem_read <= 1'b1;
                                bus.mem_addr <= bus.ex_alu_result[ADDR_W-1:0];
                            end
                        end else if (bus.ex_store) begin
                            bus.wb_valid    <= 1'b1;
                            bus.wb_regwrite <= 1'b0;
                            bus.wb_is_load  <= 1'b0;
                            bus.fault       <= addr_fault;
                            if (!addr_fault) begin
                                bus.mem_write <= 1'b1;
                                bus.mem_addr  <= bus.ex_alu_result[ADDR_W-1:0];
                                bus.mem_wdata <= bus.ex_store_data;
                                bus.st_count  <= sat_inc(bus.st_count);
                            end
                        end else begin
                            bus.wb_valid    <= 1'b1;
                            bus.wb_data     <= bus.ex_alu_result;
                            bus.wb_rd       <= bus.ex_rd;
                            bus.wb_regwrite <= bus.ex_regwrite;
                            bus.wb_is_load  <= 1'b0;
                        end
                    end
                end
                // Memory registers the read during this cycle.
                LD_ISSUE: state <= LD_CAPTURE;
                // Read data is valid now; retire the load on the next edge.
                LD_CAPTURE: begin
                    state           <= IDLE;
                    bus.wb_valid    <= 1'b1;
                    bus.wb_data     <= ld_flt_p1 ? '0 : bus.mem_rdata;
                    bus.wb_rd       <= ld_rd_p1;
                    bus.wb_regwrite <= ld_rw_p1 && !ld_flt_p1;
                    bus.wb_is_load  <= 1'b1;
                    bus.fault       <= ld_flt_p1;
                    if (!ld_flt_p1)
                        bus.ld_count <= sat_inc(bus.ld_count);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a registered-read data memory model.
module tb_mem_access_unit;
    localparam int DATA_W    = 19;
    localparam int ADDR_W    = 8;
    localparam int REG_W     = 3;
    localparam int MEM_DEPTH = 226;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam int OP_ALU  = 0;
    localparam int OP_ST   = 1;
    localparam int OP_LD   = 2;
    localparam int OP_LDST = 3;
    localparam int NVEC    = 12;

    typedef struct {
        int                op;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sdata;
        logic [REG_W-1:0]  rd;
        logic              rw;
        logic [DATA_W-1:0] exp_data;
        logic              exp_rw;
        int                exp_lat;
        logic              exp_fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)) mif ();

    mem_access_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (mif.master)
    );

    logic [DATA_W-1:0] mem [0:255];

    always @(posedge clk) begin
        if (reset) begin
            mem[20]  <= 19'h00ABC;
            mem[225] <= 19'h3C3C3;
        end else if (mif.mem_write) begin
            mem[mif.mem_addr] <= mif.mem_wdata;
        end
        if (mif.mem_read)
            mif.mem_rdata <= mem[mif.mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ld  = 0;
    int exp_st  = 0;
    vec_t vecs [NVEC];

    function automatic int sat(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mif.ex_valid      = 1'b0;
        mif.ex_load       = 1'b0;
        mif.ex_store      = 1'b0;
        mif.ex_alu_result = '0;
        mif.ex_store_data = '0;
        mif.ex_rd         = '0;
        mif.ex_regwrite   = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0, wb_cnt = 0, rd_cnt = 0, wr_cnt = 0, both = 0;
        logic [DATA_W-1:0] g_data = '0, g_wdata = '0;
        logic [ADDR_W-1:0] g_addr = '0;
        logic [REG_W-1:0]  g_rd = '0;
        logic g_rw = 1'b0, g_isld = 1'b0, g_flt = 1'b0, rdy1 = 1'b0;
        logic is_ld;
        logic exp_rdp, exp_wrp;
        is_ld   = (v.op == OP_LD || v.op == OP_LDST);
        exp_rdp = is_ld && !v.exp_fault;
        exp_wrp = (v.op == OP_ST) && !v.exp_fault;

        @(negedge clk);
        mif.ex_valid      = 1'b1;
        mif.ex_load       = is_ld;
        mif.ex_store      = (v.op == OP_ST || v.op == OP_LDST);
        mif.ex_alu_result = v.alu;
        mif.ex_store_data = v.sdata;
        mif.ex_rd         = v.rd;
        mif.ex_regwrite   = v.rw;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) rdy1 = mif.ex_ready;
            if (mif.wb_valid) begin
                wb_cnt++;
                lat    = k;
                g_data = mif.wb_data;
                g_rd   = mif.wb_rd;
                g_rw   = mif.wb_regwrite;
                g_isld = mif.wb_is_load;
                g_flt  = mif.fault;
            end
            if (mif.mem_read)  begin rd_cnt++; g_addr = mif.mem_addr; end
            if (mif.mem_write) begin wr_cnt++; g_addr = mif.mem_addr; g_wdata = mif.mem_wdata; end
            if (mif.mem_read && mif.mem_write) both++;
            if (k == 1) idle_inputs();
        end

        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_wb_pulses", idx), wb_cnt, 1);
        check($sformatf("v%0d_ready_t1", idx), {31'b0, rdy1}, {31'b0, !is_ld});
        check($sformatf("v%0d_rd_pulses", idx), rd_cnt, {31'b0, exp_rdp});
        check($sformatf("v%0d_wr_pulses", idx), wr_cnt, {31'b0, exp_wrp});
        check($sformatf("v%0d_strobe_overlap", idx), both, 0);
        check($sformatf("v%0d_wb_regwrite", idx), {31'b0, g_rw}, {31'b0, v.exp_rw});
        check($sformatf("v%0d_wb_is_load", idx), {31'b0, g_isld}, {31'b0, is_ld});
        check($sformatf("v%0d_fault", idx), {31'b0, g_flt}, {31'b0, v.exp_fault});
        if (v.op != OP_ST && !v.exp_fault)
            check($sformatf("v%0d_wb_data", idx), g_data, v.exp_data);
        if (v.op != OP_ST)
            check($sformatf("v%0d_wb_rd", idx), g_rd, v.rd);
        if (exp_rdp || exp_wrp)
            check($sformatf("v%0d_mem_addr", idx), g_addr, v.alu[ADDR_W-1:0]);
        if (exp_wrp)
            check($sformatf("v%0d_mem_wdata", idx), g_wdata, v.sdata);

        if (exp_rdp) exp_ld = sat(exp_ld);
        if (exp_wrp) exp_st = sat(exp_st);
        check($sformatf("v%0d_ld_count", idx), mif.ld_count, exp_ld);
        check($sformatf("v%0d_st_count", idx), mif.st_count, exp_st);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] prev_val;
        logic [ADDR_W-1:0] prev_addr;
        logic [REG_W-1:0]  prev_rd;

        vecs[0] = '{OP_ST,   19'd10,  19'h5A5A5, 3'd0, 1'b0, 19'h0,     1'b0, 1, 1'b0};
        vecs[1] = '{OP_LD,   19'd10,  19'h0,     3'd3, 1'b1, 19'h5A5A5, 1'b1, 3, 1'b0};
        vecs[2] = '{OP_ALU,  19'h7FFFF, 19'h0,   3'd5, 1'b1, 19'h7FFFF, 1'b1, 1, 1'b0};
        vecs[3] = '{OP_LDST, 19'd20,  19'h7FFFF, 3'd2, 1'b1, 19'h00ABC, 1'b1, 3, 1'b0};
        vecs[4] = '{OP_LD,   19'd225, 19'h0,     3'd6, 1'b1, 19'h3C3C3, 1'b1, 3, 1'b0};
        vecs[5] = '{OP_ALU,  19'h12345, 19'h0,   3'd7, 1'b0, 19'h12345, 1'b0, 1, 1'b0};
        vecs[6] = '{OP_ST,   19'd100, 19'h2AAAA, 3'd0, 1'b0, 19'h0,     1'b0, 1, 1'b0};
        vecs[7] = '{OP_LD,   19'd100, 19'h0,     3'd1, 1'b1, 19'h2AAAA, 1'b1, 3, 1'b0};
`ifdef MEM_ADDR_CHECK_EN
        vecs[8]  = '{OP_ST,  19'd230, 19'h11111, 3'd0, 1'b0, 19'h0,     1'b0, 1, 1'b1};
        vecs[9]  = '{OP_LD,  19'd230, 19'h0,     3'd4, 1'b1, 19'h0,     1'b0, 3, 1'b1};
        vecs[10] = '{OP_ST,  19'd225, 19'h11111, 3'd0, 1'b0, 19'h0,     1'b0, 1, 1'b0};
        vecs[11] = '{OP_LD,  19'd225, 19'h0,     3'd4, 1'b1, 19'h11111, 1'b1, 3, 1'b0};
`else
        vecs[8]  = '{OP_ST,  19'h40021, 19'h0F0F0, 3'd0, 1'b0, 19'h0,   1'b0, 1, 1'b0};
        vecs[9]  = '{OP_LD,  19'h7FF21, 19'h0,   3'd4, 1'b1, 19'h0F0F0, 1'b1, 3, 1'b0};
        vecs[10] = '{OP_ST,  19'd230, 19'h11111, 3'd0, 1'b0, 19'h0,     1'b0, 1, 1'b0};
        vecs[11] = '{OP_LD,  19'd230, 19'h0,     3'd4, 1'b1, 19'h11111, 1'b1, 3, 1'b0};
`endif

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ex_ready",    {31'b0, mif.ex_ready}, 1);
        check("rst_mem_read",    {31'b0, mif.mem_read}, 0);
        check("rst_mem_write",   {31'b0, mif.mem_write}, 0);
        check("rst_mem_addr",    mif.mem_addr, 0);
        check("rst_mem_wdata",   mif.mem_wdata, 0);
        check("rst_wb_valid",    {31'b0, mif.wb_valid}, 0);
        check("rst_wb_regwrite", {31'b0, mif.wb_regwrite}, 0);
        check("rst_wb_rd",       mif.wb_rd, 0);
        check("rst_wb_data",     mif.wb_data, 0);
        check("rst_wb_is_load",  {31'b0, mif.wb_is_load}, 0);
        check("rst_ld_count",    mif.ld_count, 0);
        check("rst_st_count",    mif.st_count, 0);
        check("rst_fault",       {31'b0, mif.fault}, 0);

        for (int i = 0; i < NVEC; i++)
            run_vec(i, vecs[i]);
        check("ldst_word20_unchanged", mem[20], 19'h00ABC);

        // Back-to-back ALU ops: one result per cycle.
        prev_val = '0;
        prev_rd  = '0;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("alu_b2b%0d_valid", i), {31'b0, mif.wb_valid}, 1);
                check($sformatf("alu_b2b%0d_data", i), mif.wb_data, prev_val);
                check($sformatf("alu_b2b%0d_rd", i), mif.wb_rd, prev_rd);
            end
            if (i < 5) begin
                prev_val          = 19'h7FFFF - DATA_W'(i * 19'h1111);
                prev_rd           = REG_W'(i);
                mif.ex_valid      = 1'b1;
                mif.ex_alu_result = prev_val;
                mif.ex_rd         = prev_rd;
                mif.ex_regwrite   = 1'b1;
            end else begin
                idle_inputs();
            end
        end
        @(negedge clk);
        check("alu_b2b_idle_valid", {31'b0, mif.wb_valid}, 0);

        // Back-to-back stores, long enough to drive st_count into saturation.
        prev_addr = '0;
        prev_val  = '0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_st = sat(exp_st);
                check($sformatf("st_b2b%0d_write", i), {31'b0, mif.mem_write}, 1);
                check($sformatf("st_b2b%0d_addr", i), mif.mem_addr, prev_addr);
                check($sformatf("st_b2b%0d_wdata", i), mif.mem_wdata, prev_val);
                check($sformatf("st_b2b%0d_count", i), mif.st_count, exp_st);
            end
            if (i < 20) begin
                prev_addr         = ADDR_W'(120 + i);
                prev_val          = DATA_W'(i * 3 + 1);
                mif.ex_valid      = 1'b1;
                mif.ex_store      = 1'b1;
                mif.ex_alu_result = {11'b0, prev_addr};
                mif.ex_store_data = prev_val;
            end else begin
                idle_inputs();
            end
        end
        @(negedge clk);
        check("st_sat_value", mif.st_count, CNT_MAX);
        check("st_idle_write", {31'b0, mif.mem_write}, 0);
        check("st_idle_addr_hold", mif.mem_addr, 8'd139);

        // Reset while the load sits in LD_CAPTURE must abort it.
        @(negedge clk);
        mif.ex_valid      = 1'b1;
        mif.ex_load       = 1'b1;
        mif.ex_alu_result = 19'd10;
        mif.ex_rd         = 3'd3;
        mif.ex_regwrite   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("abort_pre_ready", {31'b0, mif.ex_ready}, 0);
        reset = 1'b1;
        #1;
        check("abort_ready",    {31'b0, mif.ex_ready}, 1);
        check("abort_ld_count", mif.ld_count, 0);
        check("abort_st_count", mif.st_count, 0);
        check("abort_wb_valid", {31'b0, mif.wb_valid}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_post%0d_wb_valid", k), {31'b0, mif.wb_valid}, 0);
            check($sformatf("abort_post%0d_ready", k), {31'b0, mif.ex_ready}, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
